matrix_scan_driver: RTL
=======================

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 SHALL provide parameter DWELL, default 16'd200: system-clock cycles each column stays lit; legal range 1..65535.
REQ-002 SHALL provide port in_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port in_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port in_enable  input  1  scan enable, level-sensitive.
REQ-005 SHALL provide port in_wr_en  input  1  framebuffer write strobe, one write per cycle.
REQ-006 SHALL provide port in_wr_addr  input  4  column index written.
REQ-007 SHALL provide port in_wr_data  input  16  row bits for that column; bit n lights row n.
REQ-008 SHALL provide port out_row_clk  output  1  row shift clock; drives the row shift register clock.
REQ-009 SHALL provide port out_row_data  output  1  serial row bit, sampled on out_row_clk rising edge.
REQ-010 SHALL provide port out_column  output  4  binary column select for the column decoder.
REQ-011 SHALL provide port out_blank  output  1  high = display must be dark (rows invalid).
REQ-012 SHALL provide port out_frame_start  output  1  one-cycle pulse when column 0 scan begins.

Function
REQ-013 SHALL hold a 16x16 framebuffer; in_wr_en writes in_wr_data to entry in_wr_addr at the clock edge, in any state.
REQ-014 SHALL copy the current column's entry into a 16-bit shadow on entry to SHIFT; writes after that copy affect only the next scan of that column.
REQ-015 SHALL, when copy and write target the same entry in the same cycle, copy the pre-write value.
REQ-016 SHALL implement states IDLE, SHIFT, LATCH, DWELL; all outputs registered.
REQ-017 IDLE: out_blank=1, out_row_clk=0; on in_enable=1 -> SHIFT with shadow load.
REQ-018 SHIFT: 32 cycles, 16 bit-slots of 2 cycles; slot k phase 0 drives out_row_data=shadow[15-k], out_row_clk=0; phase 1 holds data, out_row_clk=1.
REQ-019 SHIFT order SHALL be MSB first, so after 16 pulses the downstream row register bit n equals shadow[n].
REQ-020 After slot 15 phase 1 -> LATCH: out_row_clk=0, out_column=current column, out_blank=0, dwell counter=DWELL-1.
REQ-021 DWELL: counter decrements each cycle; at 0, out_blank=1 and column index increments mod 16 (15 wraps to 0).
REQ-022 At the end of DWELL SHALL go to SHIFT with shadow load if in_enable=1, else to IDLE.
REQ-023 Column period under continuous enable SHALL be exactly 33+DWELL cycles; frame = 16*(33+DWELL).
REQ-024 out_frame_start SHALL pulse for 1 cycle in the first SHIFT cycle of column 0, including the first scan after reset.
REQ-025 in_enable deasserted mid-SHIFT or mid-DWELL SHALL NOT abort; the current column completes, then IDLE.
REQ-026 out_blank SHALL be 1 during every SHIFT cycle; out_column SHALL change only in LATCH.
REQ-027 Column index SHALL persist across IDLE; scanning resumes at the next column, not column 0.

Reset
REQ-028 in_rst_n=0 SHALL immediately force: state IDLE, column index 0, out_row_clk=0, out_row_data=0, out_column=0, out_blank=1, out_frame_start=0, counters 0.
REQ-029 Reset SHALL clear all framebuffer entries to 16'h0000.
REQ-030 Reset asserted mid-operation SHALL abandon the partial shift; after release the first scan starts at column 0 with out_frame_start.

Verification
REQ-031 Reset, write col0=16'hA5C3, enable, DWELL=4 -> 16 row_clk pulses with data 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; the modelled row register reads 16'hA5C3 when blank falls; out_column=0.
REQ-032 Continuous enable, DWELL=4 -> out_blank low for exactly 4 cycles per column, period 37 cycles, column sequence 0..15,0; frame_start every 592 cycles.
REQ-033 Write col3 during col3 SHIFT -> current scan shifts the old data; the next frame shows the new data.
REQ-034 Drop in_enable during col5 SHIFT -> col5 completes LATCH and DWELL, then IDLE with blank=1; re-enable -> scan resumes at col6 with no frame_start.
REQ-035 Assert in_rst_n=0 at slot 7 of col9 -> outputs take reset values in the same cycle; after release, frame_start fires and col0 shifts 16'h0000.

Source files
------------

// File: rtl/matrix_scan_driver.sv
// 16x16 LED matrix column scanner: framebuffer, serial row shifter and
// column dwell timing with registered outputs.
module matrix_scan_driver #(
  parameter logic [15:0] DWELL = 16'd200
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_enable,
  input  logic        in_wr_en,
  input  logic [3:0]  in_wr_addr,
  input  logic [15:0] in_wr_data,
  output logic        out_row_clk,
  output logic        out_row_data,
  output logic [3:0]  out_column,
  output logic        out_blank,
  output logic        out_frame_start
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] dwell_q, dwell_d;
  logic [3:0]  col_q, col_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] fb_q [16];

  logic        row_clk_q, row_clk_d;
  logic        row_data_q, row_data_d;
  logic [3:0]  column_q, column_d;
  logic        blank_q, blank_d;
  logic        fs_q, fs_d;

  logic        start;
  logic [3:0]  start_col;
  logic [3:0]  slot;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    dwell_d    = dwell_q;
    col_d      = col_q;
    shadow_d   = shadow_q;
    row_clk_d  = 1'b0;
    row_data_d = row_data_q;
    column_d   = column_q;
    blank_d    = 1'b1;
    fs_d       = 1'b0;
    start      = 1'b0;
    start_col  = col_q;
    slot       = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (in_enable) start = 1'b1;
      end
      S_SHIFT: begin
        if (bit_q == 5'd31) begin
          state_d  = S_LATCH;
          blank_d  = 1'b0;
          column_d = col_q;
          dwell_d  = DWELL - 16'd1;
        end else begin
          bit_d      = bit_q + 5'd1;
          slot       = ~bit_d[4:1];
          row_data_d = shadow_q[slot];
          row_clk_d  = bit_d[0];
        end
      end
      S_LATCH: begin
        state_d = S_DWELL;
        blank_d = (dwell_q == 16'd0);
      end
      S_DWELL: begin
        if (dwell_q == 16'd0) begin
          col_d     = col_q + 4'd1;
          start_col = col_q + 4'd1;
          if (in_enable) start = 1'b1;
          else state_d = S_IDLE;
        end else begin
          dwell_d = dwell_q - 16'd1;
          blank_d = (dwell_q == 16'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Shadow takes the pre-write entry, so same-edge writes land next scan
    if (start) begin
      state_d    = S_SHIFT;
      bit_d      = 5'd0;
      shadow_d   = fb_q[start_col];
      row_data_d = fb_q[start_col][15];
      fs_d       = (start_col == 4'd0);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= S_IDLE;
      bit_q      <= '0;
      dwell_q    <= '0;
      col_q      <= '0;
      shadow_q   <= '0;
      row_clk_q  <= 1'b0;
      row_data_q <= 1'b0;
      column_q   <= '0;
      blank_q    <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      shadow_q   <= shadow_d;
      row_clk_q  <= row_clk_d;
      row_data_q <= row_data_d;
      column_q   <= column_d;
      blank_q    <= blank_d;
      fs_q       <= fs_d;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < 16; i++) fb_q[i] <= '0;
    end else if (in_wr_en) begin
      fb_q[in_wr_addr] <= in_wr_data;
    end
  end

  assign out_row_clk     = row_clk_q;
  assign out_row_data    = row_data_q;
  assign out_column      = column_q;
  assign out_blank       = blank_q;
  assign out_frame_start = fs_q;

endmodule
